// File: rtl/gray2bin_pipe.sv
// ============================================================================
// gray2bin_pipe : pipelined Gray-to-binary decoder with valid/ready on both
//                 sides; the prefix-XOR chain is sliced across STAGES registers.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module gray2bin_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int STAGES     = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  gray_valid_i,
   output logic                  gray_ready_o,
   input  logic [DATA_WIDTH-1:0] gray_data_i,
   output logic                  bin_valid_o,
   input  logic                  bin_ready_i,
   output logic [DATA_WIDTH-1:0] bin_data_o
);

   localparam int c_slice = (STAGES < 1) ? 1 : (DATA_WIDTH + STAGES - 1) / STAGES;

   if (DATA_WIDTH < 2 || STAGES < 1 || (STAGES - 1) * c_slice >= DATA_WIDTH) begin : g_bad_cfg
      $error("gray2bin_pipe: illegal DATA_WIDTH/STAGES combination (empty stage slice)");
   end

   logic [STAGES-1:0]                 r_valid;
   logic [STAGES-1:0][DATA_WIDTH-1:0] r_gray;
   logic [STAGES-1:0][DATA_WIDTH-1:0] r_bin;
   logic [STAGES-1:0]                 r_carry;
   logic [STAGES-1:0]                 w_load;
   logic                              w_unused;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int c_hi = DATA_WIDTH - 1 - s * c_slice;
      localparam int c_lo = (c_hi - c_slice + 1 < 0) ? 0 : c_hi - c_slice + 1;

      logic                  w_vin;
      logic                  w_cin;
      logic                  w_cout;
      logic [DATA_WIDTH-1:0] w_gin;
      logic [DATA_WIDTH-1:0] w_bin_in;
      logic [DATA_WIDTH-1:0] w_bin_nx;
      logic                  w_unused;

      if (s == 0) begin : g_head
         assign w_vin    = gray_valid_i;
         assign w_gin    = gray_data_i;
         assign w_bin_in = '0;
         assign w_cin    = 1'b0;
      end else begin : g_body
         assign w_vin    = r_valid[s-1];
         assign w_gin    = r_gray[s-1];
         assign w_bin_in = r_bin[s-1];
         assign w_cin    = r_carry[s-1];
      end

      // Each resolved bit is the carry XOR the Gray bits from the slice top down to it
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
         if (i >= c_lo && i <= c_hi) begin : g_res
            assign w_bin_nx[i] = w_cin ^ (^w_gin[c_hi:i]);
         end else begin : g_pass
            assign w_bin_nx[i] = w_bin_in[i];
         end
      end

      assign w_cout   = w_bin_nx[c_lo];
      assign w_unused = ^w_bin_in[c_hi:c_lo];

      // A stage can be written if any stage from here to the output has a hole
      assign w_load[s] = ~(&r_valid[STAGES-1:s]) | bin_ready_i;

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            r_valid[s] <= 1'b0;
            r_gray[s]  <= '0;
            r_bin[s]   <= '0;
            r_carry[s] <= 1'b0;
         end else if (w_load[s]) begin
            r_valid[s] <= w_vin;
            if (w_vin) begin
               r_gray[s]  <= w_gin;
               r_bin[s]   <= w_bin_nx;
               r_carry[s] <= w_cout;
            end
         end
      end
   end

   assign gray_ready_o = w_load[0];
   assign bin_valid_o  = r_valid[STAGES-1];
   assign bin_data_o   = r_bin[STAGES-1];
   assign w_unused     = ^{r_gray[STAGES-1], r_carry[STAGES-1]};

endmodule

`default_nettype wire

// File: tb/tb_gray2bin_pipe.sv
// ============================================================================
// tb_gray2bin_pipe : scoreboard bench for gray2bin_pipe (8/4 main instance plus
//                    a sweep of width/stage configurations).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_gray2bin_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] cur_exp;
   logic       sweep_run;
   logic       sweep_done;
   logic       sweep_ready;
   logic       rnd_on;

   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gray2bin_pipe #(.DATA_WIDTH(8), .STAGES(4)) u_dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .gray_valid_i (in_valid),
      .gray_ready_o (in_ready),
      .gray_data_i  (in_data),
      .bin_valid_o  (out_valid),
      .bin_ready_i  (out_ready),
      .bin_data_o   (out_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] b2g(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

   // Scoreboard: push on accepted input, pop and compare on emitted output
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
            else                   chk("sb_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [7:0] g, input logic [7:0] e);
      in_valid = 1'b1;
      in_data  = g;
      cur_exp  = e;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic probe(input logic [7:0] e);
      int n;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
      chk("latency", n, 4);
      chk("decode", out_data, e);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
   endtask

   // Sweep instances: continuous stream, every word checked for value and latency
   for (genvar k = 0; k < 4; k++) begin : g_sweep
      localparam int W = (k == 0) ? 4 : (k == 1) ? 16 : (k == 2) ? 17 : 32;
      localparam int S = (k == 0) ? 1 : (k == 1) ? 4  : (k == 2) ? 5  : 32;

      logic         s_valid;
      logic         s_rdy;
      logic         s_ovalid;
      logic [W-1:0] s_gray;
      logic [W-1:0] s_bin;
      logic [W-1:0] s_out;
      logic [W-1:0] s_q[$];
      int           s_t[$];

      gray2bin_pipe #(.DATA_WIDTH(W), .STAGES(S)) u_sw (
         .clk_i        (clk),
         .rst_n_i      (rst_n),
         .gray_valid_i (s_valid),
         .gray_ready_o (s_rdy),
         .gray_data_i  (s_gray),
         .bin_valid_o  (s_ovalid),
         .bin_ready_i  (sweep_ready),
         .bin_data_o   (s_out)
      );

      initial begin
         s_valid = 1'b0;
         s_bin   = '0;
         s_gray  = '0;
      end

      always @(posedge clk) begin
         #1;
         if (sweep_run) begin
            s_valid = 1'b1;
            s_bin   = (k == 0) ? s_bin + W'(1) : W'($urandom());
            s_gray  = s_bin ^ (s_bin >> 1);
         end else begin
            s_valid = 1'b0;
         end
      end

      always @(negedge clk) begin
         if (rst_n) begin
            if (s_valid && s_rdy) begin
               s_q.push_back(s_bin);
               s_t.push_back(cyc);
            end
            if (s_ovalid) begin
               if (s_q.size() == 0) begin
                  chk($sformatf("sw%0d_underflow", W), s_q.size(), 1);
               end else begin
                  chk($sformatf("sw%0d_data", W), s_out, s_q.pop_front());
                  chk($sformatf("sw%0d_latency", W), cyc - s_t.pop_front(), S);
               end
            end
         end
      end

      initial begin
         wait (sweep_done);
         chk($sformatf("sw%0d_drain", W), s_q.size(), 0);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] dir_g[4];
      logic [7:0] dir_b[4];
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;
      cur_exp     = '0;
      sweep_run   = 1'b0;
      sweep_done  = 1'b0;
      sweep_ready = 1'b1;
      rnd_on      = 1'b0;
      dir_g = '{8'h0C, 8'hFF, 8'h80, 8'h00};
      dir_b = '{8'h08, 8'hAA, 8'hFF, 8'h00};

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ready", in_ready, 1);

      // Directed decodes with exact latency
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         send(dir_g[i], dir_b[i]);
         probe(dir_b[i]);
      end

      // Full-rate stream of Gray codes 0..255
      @(posedge clk);
      #1;
      fork
         for (int i = 0; i < 256; i++) send(b2g(8'(i)), 8'(i));
         begin
            int n;
            int bub;
            bub = 0;
            for (n = 1; n <= 20; n++) begin
               @(negedge clk);
               if (out_valid) break;
            end
            chk("stream_first", n, 5);
            for (int j = 0; j < 255; j++) begin
               @(negedge clk);
               if (!out_valid) bub++;
            end
            chk("stream_bubbles", bub, 0);
         end
      join
      drain();

      // Backpressure: output stalled for 10 cycles while input streams
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      fork
         for (int i = 0; i < 10; i++) send(b2g(8'(100 + i)), 8'(100 + i));
         begin
            int         acc;
            logic [7:0] held;
            logic       have;
            acc  = 0;
            have = 1'b0;
            held = '0;
            for (int j = 0; j < 10; j++) begin
               @(negedge clk);
               if (in_valid && in_ready) acc++;
               if (out_valid) begin
                  if (have) chk("stall_hold", out_data, held);
                  else begin
                     held = out_data;
                     have = 1'b1;
                  end
               end
            end
            chk("stall_accepts", acc, 4);
            chk("stall_ready", in_ready, 0);
            chk("stall_first", held, 100);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three words in flight
      @(posedge clk);
      #1;
      for (int i = 1; i <= 3; i++) send(b2g(8'(i)), 8'(i));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      send(8'h80, 8'hFF);
      probe(8'hFF);
      drain();

      // Random valid/ready loop-back through a Gray encoder
      @(posedge clk);
      #1;
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               logic [7:0] b;
               b = 8'($urandom());
               if ($urandom_range(1, 0) == 1) begin
                  @(posedge clk);
                  #1;
               end
               send(b2g(b), b);
            end
            rnd_on = 1'b0;
         end
         while (rnd_on) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(1, 0) == 1);
         end
      join
      out_ready = 1'b1;
      drain();

      // Parameter sweep
      @(negedge clk);
      sweep_run = 1'b1;
      repeat (200) @(negedge clk);
      sweep_run = 1'b0;
      repeat (45) @(negedge clk);
      sweep_done = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
